// File: rtl/nzcv_branch_cond_if.sv
// Branch/flag bus between the ALU, branch unit and the NZCV condition block.
// Master drives requests and flag traffic; slave returns decisions.
interface nzcv_branch_cond_if #(
  parameter int N = 64
) ();
  logic         i_flag_issue;
  logic         o_issue_ready;
  logic         i_flags_we;
  logic [3:0]   i_nzcv;
  logic         i_br_valid;
  logic         o_br_ready;
  logic [3:0]   i_br_cond;
  logic [N-1:0] i_br_pc;
  logic [N-1:0] i_br_offset;
  logic         o_res_valid;
  logic         o_taken;
  logic [N-1:0] o_pc_next;
  logic [3:0]   o_nzcv;

  modport master (
    output i_flag_issue,
    output i_flags_we,
    output i_nzcv,
    output i_br_valid,
    output i_br_cond,
    output i_br_pc,
    output i_br_offset,
    input  o_issue_ready,
    input  o_br_ready,
    input  o_res_valid,
    input  o_taken,
    input  o_pc_next,
    input  o_nzcv
  );

  modport slave (
    input  i_flag_issue,
    input  i_flags_we,
    input  i_nzcv,
    input  i_br_valid,
    input  i_br_cond,
    input  i_br_pc,
    input  i_br_offset,
    output o_issue_ready,
    output o_br_ready,
    output o_res_valid,
    output o_taken,
    output o_pc_next,
    output o_nzcv
  );
endinterface

// File: rtl/nzcv_branch_cond.sv
// NZCV flag register, in-flight flag scoreboard and A64 condition evaluator.
// Produces a registered taken decision and next PC per accepted branch.
module nzcv_branch_cond #(
  parameter int N = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  nzcv_branch_cond_if.slave      bus
);

  logic [3:0]   nzcv_q, nzcv_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         res_valid_q, res_valid_d;
  logic         taken_q, taken_d;
  logic [N-1:0] pc_next_q, pc_next_d;

  logic [3:0]   eff_nzcv;
  logic         f_n, f_z, f_c, f_v;
  logic         base;
  logic         cond_true;
  logic         br_ready;
  logic         accept;

  // Final write-back is forwarded so a branch can resolve on it
  assign eff_nzcv = bus.i_flags_we ? bus.i_nzcv : nzcv_q;
  assign f_n = eff_nzcv[3];
  assign f_z = eff_nzcv[2];
  assign f_c = eff_nzcv[1];
  assign f_v = eff_nzcv[0];

  always_comb begin
    base = 1'b0;
    unique case (bus.i_br_cond[3:1])
      3'd0: base = f_z;
      3'd1: base = f_c;
      3'd2: base = f_n;
      3'd3: base = f_v;
      3'd4: base = f_c & ~f_z;
      3'd5: base = (f_n == f_v);
      3'd6: base = ~f_z & (f_n == f_v);
      3'd7: base = 1'b1;
      default: base = 1'b0;
    endcase
  end

  // Odd codes invert, except NV which behaves as AL
  assign cond_true = (bus.i_br_cond[3:1] == 3'd7)
                   ? 1'b1
                   : (base ^ bus.i_br_cond[0]);

  assign br_ready =
    ~bus.i_flag_issue &
    ((cnt_q == 2'd0) |
     ((cnt_q == 2'd1) & bus.i_flags_we));

  assign accept = bus.i_br_valid & br_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_flag_issue & ~bus.i_flags_we) begin
      if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
    end else if (bus.i_flags_we & ~bus.i_flag_issue) begin
      if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    nzcv_d = nzcv_q;
    if (bus.i_flags_we) nzcv_d = bus.i_nzcv;
  end

  always_comb begin
    res_valid_d = accept;
    taken_d     = taken_q;
    pc_next_d   = pc_next_q;
    if (accept) begin
      taken_d   = cond_true;
      pc_next_d = cond_true
                ? bus.i_br_pc + bus.i_br_offset
                : bus.i_br_pc + N'(4);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nzcv_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      pc_next_q   <= '0;
    end else begin
      nzcv_q      <= nzcv_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      pc_next_q   <= pc_next_d;
    end
  end

  assign bus.o_issue_ready = (cnt_q != 2'd3);
  assign bus.o_br_ready    = br_ready;
  assign bus.o_res_valid   = res_valid_q;
  assign bus.o_taken       = taken_q;
  assign bus.o_pc_next     = pc_next_q;
  assign bus.o_nzcv        = nzcv_q;

endmodule

// File: tb/tb_nzcv_branch_cond.sv
// Directed bench for nzcv_branch_cond with an expected-result queue.
// Bench-side model tracks flags, in-flight count and branch decisions.
module tb_nzcv_branch_cond;

  logic clk;
  logic rst_n;

  nzcv_branch_cond_if #(.N(64)) bus ();

  nzcv_branch_cond #(.N(64)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic        t;
    logic [63:0] pc;
  } exp_t;

  exp_t        q[$];
  int          n_asrt;
  int          n_fail;
  int          cnt;
  logic [3:0]  mnz;
  logic        last_t;
  logic [63:0] last_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic step(input logic iss, input logic we,
                      input logic [3:0] f, input logic v,
                      input logic [3:0] c, input logic [63:0] pc,
                      input logic [63:0] off);
    logic rdy, acc, t;
    exp_t e;
    bus.i_flag_issue = iss;
    bus.i_flags_we   = we;
    bus.i_nzcv       = f;
    bus.i_br_valid   = v;
    bus.i_br_cond    = c;
    bus.i_br_pc      = pc;
    bus.i_br_offset  = off;
    #1;
    rdy = !iss && (cnt == 0 || (cnt == 1 && we));
    chk("br_ready", 64'(bus.o_br_ready), 64'(rdy));
    chk("issue_ready", 64'(bus.o_issue_ready), 64'(cnt != 3));
    acc = v && rdy;
    if (acc) begin
      t = ref_cond(c, we ? f : mnz);
      e.t  = t;
      e.pc = t ? pc + off : pc + 64'd4;
      q.push_back(e);
    end
    if (we) mnz = f;
    if (iss && !we && cnt != 3) cnt++;
    else if (we && !iss && cnt != 0) cnt--;
    @(posedge clk);
    #1;
    chk("res_valid", 64'(bus.o_res_valid), 64'(acc));
    if (acc && q.size() > 0) begin
      e = q.pop_front();
      last_t  = e.t;
      last_pc = e.pc;
    end
    chk("taken", 64'(bus.o_taken), 64'(last_t));
    chk("pc_next", bus.o_pc_next, last_pc);
    chk("nzcv", 64'(bus.o_nzcv), 64'(mnz));
    @(negedge clk);
    bus.i_flag_issue = 1'b0;
    bus.i_flags_we   = 1'b0;
    bus.i_br_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 64'(bus.o_res_valid), 64'(0));
    chk("rst_taken", 64'(bus.o_taken), 64'(0));
    chk("rst_pc_next", bus.o_pc_next, 64'(0));
    chk("rst_nzcv", 64'(bus.o_nzcv), 64'(0));
    cnt = 0;
    mnz = 4'd0;
    last_t = 1'b0;
    last_pc = 64'd0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    bus.i_flag_issue = 1'b0;
    bus.i_flags_we   = 1'b0;
    bus.i_nzcv       = 4'd0;
    bus.i_br_valid   = 1'b0;
    bus.i_br_cond    = 4'd0;
    bus.i_br_pc      = 64'd0;
    bus.i_br_offset  = 64'd0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Idle after reset, then EQ with Z=0
    step(0, 0, 4'h0, 1, 4'd0, 64'h1000, 64'h40);

    // Flag write then EQ / NE
    step(0, 1, 4'b0100, 0, 4'd0, 64'h0, 64'h0);
    step(0, 0, 4'h0, 1, 4'd0, 64'h2000, 64'h40);
    step(0, 0, 4'h0, 1, 4'd1, 64'h2000, 64'h40);

    // Full sweep; first cond of each value uses the forwarded path
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        step(0, c == 0, 4'(f), 1, 4'(c),
             {$urandom, $urandom}, {$urandom, $urandom});
      end
    end

    // GE with N=V=1, GT with Z=1
    step(0, 1, 4'b1001, 1, 4'd10, 64'h3000, 64'h100);
    step(0, 1, 4'b0100, 1, 4'd12, 64'h3000, 64'h100);

    // Hazard: issue, stalled branch, then forwarded write-back
    step(1, 0, 4'h0, 0, 4'd2, 64'h4000, 64'h80);
    step(0, 0, 4'h0, 1, 4'd2, 64'h4000, 64'h80);
    step(0, 0, 4'h0, 1, 4'd2, 64'h4000, 64'h80);
    step(0, 1, 4'b0010, 1, 4'd2, 64'h4000, 64'h80);

    // Scoreboard saturation and recovery
    step(1, 0, 4'h0, 0, 4'd0, 64'h0, 64'h0);
    step(1, 0, 4'h0, 0, 4'd0, 64'h0, 64'h0);
    step(1, 0, 4'h0, 1, 4'd14, 64'h5000, 64'h8);
    step(1, 0, 4'h0, 0, 4'd0, 64'h0, 64'h0);
    step(1, 1, 4'b1000, 0, 4'd0, 64'h0, 64'h0);
    step(0, 1, 4'b0001, 0, 4'd0, 64'h0, 64'h0);
    step(0, 1, 4'b0011, 1, 4'd14, 64'h5000, 64'h8);
    step(0, 1, 4'b0110, 0, 4'd0, 64'h0, 64'h0);
    step(0, 1, 4'b0100, 1, 4'd1, 64'h6000, 64'h8);
    step(1, 0, 4'h0, 1, 4'd14, 64'h6000, 64'h8);
    step(0, 1, 4'b0000, 1, 4'd0, 64'h6000, 64'h8);
    step(0, 0, 4'h0, 1, 4'd1, 64'h6000, 64'h8);

    // PC wrap on not-taken
    step(0, 1, 4'b0100, 1, 4'd1,
         64'hFFFF_FFFF_FFFF_FFFC, 64'h10);

    // Reset right after an accept drops the result
    step(0, 0, 4'h0, 1, 4'd14, 64'h7000, 64'h20);
    do_reset();
    step(0, 0, 4'h0, 0, 4'd0, 64'h0, 64'h0);

    // Reset with flags in flight clears the count
    step(1, 0, 4'h0, 0, 4'd0, 64'h0, 64'h0);
    step(1, 0, 4'h0, 0, 4'd0, 64'h0, 64'h0);
    do_reset();
    step(0, 0, 4'h0, 1, 4'd14, 64'h8000, 64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
